axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple request/response port from the core's memory stage into AXI4-Lite read and write transactions. It drives memory-mapped peripherals on the shared AXI4-Lite interconnect, including the PLIC priority/enable/threshold/claim-complete registers, UART and virtio. One transaction is in flight at a time. Core-side requests are latched, then replayed on AR/R or AW/W/B, and the returned data and response code are held until the core consumes them.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width; WSTRB width is DATA_W/8

Ports:
- clk  in  1  sole clock; everything is sampled on its rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  write byte strobes
- resp_valid  out  1  response available
- resp_ready  in  1  core takes the response
- resp_rdata  out  DATA_W  read data; 0 for writes
- resp_err  out  1  1 when the xRESP bit 1 was set (SLVERR/DECERR)
- axi_araddr, axi_arvalid, axi_arready, axi_arprot  AR channel (out/out/in/out; ADDR_W/1/1/3)
- axi_rdata, axi_rresp, axi_rvalid, axi_rready  R channel (in/in/in/out; DATA_W/2/1/1)
- axi_awaddr, axi_awvalid, axi_awready, axi_awprot  AW channel (out/out/in/out; ADDR_W/1/1/3)
- axi_wdata, axi_wstrb, axi_wvalid, axi_wready  W channel (out/out/out/in)
- axi_bresp, axi_bvalid, axi_bready  B channel (in/in/out; 2/1/1)

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, wstrb and we. Go to RD_ADDR if we=0, otherwise WR_REQ.
- RD_ADDR: arvalid=1 with the latched address. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata into resp_rdata, set resp_err=rresp[1], go to RESP.
- WR_REQ: awvalid and wvalid are both asserted in the same cycle on state entry.
  - Each channel has its own done flag. A channel's valid drops the cycle after its ready is sampled high.
  - AW and W may be accepted in the same cycle or in either order.
  - When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, set resp_err=bresp[1], resp_rdata=0, go to RESP.
- RESP: resp_valid=1. On resp_ready, go to IDLE.
- axi_arprot = axi_awprot = 3'b000 at all times.
- Write data and address are never presented before the request is latched.
- Valid signals never depend combinationally on ready.
- Latched address, data and strobe stay stable while the corresponding valid is high.
- rdata/bresp arriving while the block is not in RD_DATA/WR_RESP are ignored; rready/bready are 0 there.

## Timing
- Reset: all outputs 0 (req_ready, resp_valid, resp_rdata, resp_err, every axi valid/ready, addresses, wdata, wstrb). FSM goes to IDLE and both done flags clear. req_ready rises the first cycle after rst deasserts.
- Reset mid-transaction aborts immediately to IDLE with all valids 0. The slave is reset by the same rst.
- Registered outputs only, so each state costs at least one cycle.
- Read with always-ready slave, rvalid one cycle after AR: req accept cycle N, arvalid N+1, rvalid/rready N+2, resp_valid N+3. Minimum 4 cycles request to response.
- Write with always-ready slave and bvalid one cycle after W: accept N, aw/wvalid N+1, bvalid N+2, resp_valid N+3.
- Back-to-back: with resp_ready high, resp_valid lasts 1 cycle, then IDLE; the next request is accepted the following cycle.
- req_ready=0 in every state except IDLE; no request is dropped or duplicated.
- Stalls (ready low, rvalid/bvalid late) may last any number of cycles. There is no timeout.

## Test plan
- Read, always-ready slave returning 32'h0000_000A, rresp=00 at addr 32'h201004 -> resp_valid at accept+3, resp_rdata=32'h0000_000A, resp_err=0, araddr=32'h201004 while arvalid.
- Write 32'h0000_0003 to 32'h4, wstrb=4'hF -> awvalid and wvalid high together for one cycle, correct awaddr/wdata; bresp=00 -> resp_err=0, resp_rdata=0.
- AW and W acceptance skewed: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles, exactly one B accepted, resp_valid once.
- Error response: rresp=2'b10 on addr 32'h8 -> resp_err=1. Also bresp=2'b11 on a write -> resp_err=1.
- Backpressure: resp_ready low for 5 cycles -> resp_valid and data held stable, req_ready=0, no new AR issued; then 3 back-to-back reads complete in order.
- rst asserted while in RD_DATA with arvalid already accepted -> next cycle all outputs 0, state IDLE, req_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_master.sv
// Purpose: single-outstanding AXI4-Lite initiator bridging the core memory-stage req/resp port to AR/R and AW/W/B.
// Latency: 4 cycles request-accept to resp_valid with a zero-wait slave (accept, AR or AW+W, R or B, RESP).
// Backpressure: one transaction in flight; req_ready low outside IDLE, response held until resp_ready.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   req_valid/req_ready/req_we     core request handshake and direction (1 = write)
//   req_addr/req_wdata/req_wstrb   request payload, latched on acceptance
//   resp_valid/resp_ready          core response handshake
//   resp_rdata/resp_err            read data (0 for writes) and xRESP[1] error flag
//   axi_ar*/axi_r*                 AXI4-Lite read address and read data channels
//   axi_aw*/axi_w*/axi_b*          AXI4-Lite write address, write data and write response channels
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_W-1:0]     axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [2:0]            axi_arprot,

    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,

    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [2:0]            axi_awprot,

    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,

    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                 state_q;

    // Latched request payload; drives the AXI address/data buses directly so
    // they stay stable for as long as the matching valid is high.
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W/8-1:0]    wstrb_q;

    logic                   req_ready_q;
    logic                   resp_valid_q;
    logic [DATA_W-1:0]      resp_rdata_q;
    logic                   resp_err_q;

    logic                   arvalid_q;
    logic                   rready_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   bready_q;

    // Per-channel completion flags for the write request phase.
    logic                   aw_done_q;
    logic                   w_done_q;

    // Completion as seen this cycle, including a handshake happening right now,
    // so AW and W finishing in the same cycle (or in either order) advance together.
    logic                   aw_done_d;
    logic                   w_done_d;

    // Only bit 1 of xRESP distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    logic                   unused_resp_lsb;

    assign aw_done_d       = aw_done_q | (awvalid_q & axi_awready);
    assign w_done_d        = w_done_q  | (wvalid_q  & axi_wready);
    assign unused_resp_lsb = axi_rresp[0] ^ axi_bresp[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // req_ready is registered, so the first IDLE cycle after
                    // reset only raises it; acceptance needs it already high.
                    if (req_ready_q && req_valid) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end

                RD_ADDR: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (axi_rvalid) begin
                        rready_q     <= 1'b0;
                        resp_rdata_q <= axi_rdata;
                        resp_err_q   <= axi_rresp[1];
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end

                WR_REQ: begin
                    if (awvalid_q && axi_awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && axi_wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_d && w_done_d) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (axi_bvalid) begin
                        bready_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= axi_bresp[1];
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

    assign axi_araddr  = addr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_arprot  = 3'b000;
    assign axi_rready  = rready_q;

    assign axi_awaddr  = addr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awprot  = 3'b000;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;

    // Handshake stability: a presented valid and its payload hold until accepted.
    a_ar_stable: assert property (@(posedge clk) disable iff (rst)
        (axi_arvalid && !axi_arready) |=> (axi_arvalid && $stable(axi_araddr)));
    a_aw_stable: assert property (@(posedge clk) disable iff (rst)
        (axi_awvalid && !axi_awready) |=> (axi_awvalid && $stable(axi_awaddr)));
    a_w_stable: assert property (@(posedge clk) disable iff (rst)
        (axi_wvalid && !axi_wready) |=> (axi_wvalid && $stable(axi_wdata) && $stable(axi_wstrb)));
    a_resp_stable: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata) && $stable(resp_err)));
    a_one_phase: assert property (@(posedge clk) disable iff (rst)
        !((axi_arvalid || axi_rready) && (axi_awvalid || axi_wvalid || axi_bready)));

endmodule

// File: tb/tb_axi_lite_master.sv
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [2:0]  axi_arprot, axi_awprot;
    logic [1:0]  axi_rresp, axi_bresp;
    logic [3:0]  axi_wstrb;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- slave model (decides at negedge, for the coming edge) --------
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
    logic [31:0] mem [logic [31:0]];
    int          ar_fires = 0, r_fires = 0, aw_fires = 0, w_fires = 0, b_fires = 0;
    bit          ar_f, r_f, aw_f, w_f, b_f, r_pend, aw_got, w_got;
    int          ar_c, aw_c, w_c, r_c, b_c;
    logic [31:0] ar_a, aw_a, w_d, wr_tmp;
    logic [3:0]  w_s;

    initial begin
        axi_arready = 0; axi_awready = 0; axi_wready = 0;
        axi_rvalid = 0; axi_rdata = 32'hDEADBEEF; axi_rresp = 2'b10;
        axi_bvalid = 0; axi_bresp = 2'b10;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi_arready = 0; axi_awready = 0; axi_wready = 0;
                axi_rvalid = 0; axi_rdata = 32'hDEADBEEF; axi_rresp = 2'b10;
                axi_bvalid = 0; axi_bresp = 2'b10;
                {ar_f, r_f, aw_f, w_f, b_f, r_pend, aw_got, w_got} = '0;
                ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
            end else begin
                if (r_f) begin axi_rvalid = 0; axi_rdata = 32'hDEADBEEF; axi_rresp = 2'b10; r_fires++; end
                if (b_f) begin axi_bvalid = 0; axi_bresp = 2'b10; b_fires++; end
                if (ar_f) begin r_pend = 1; r_c = 0; ar_fires++; end
                if (aw_f) begin aw_got = 1; aw_fires++; end
                if (w_f) begin w_got = 1; w_fires++; end
                if (r_pend) begin
                    if (r_c >= r_dly) begin
                        axi_rvalid = 1;
                        axi_rdata  = mem.exists(ar_a) ? mem[ar_a] : 32'h0;
                        axi_rresp  = r_resp;
                        r_pend     = 0;
                    end else r_c++;
                end
                if (aw_got && w_got) begin
                    if (b_c >= b_dly) begin
                        wr_tmp = mem.exists(aw_a) ? mem[aw_a] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (w_s[i]) wr_tmp[8*i +: 8] = w_d[8*i +: 8];
                        mem[aw_a]  = wr_tmp;
                        axi_bvalid = 1;
                        axi_bresp  = b_resp;
                        aw_got = 0; w_got = 0; b_c = 0;
                    end else b_c++;
                end
                if (axi_arvalid) begin axi_arready = (ar_c >= ar_dly); ar_c++; end
                else begin axi_arready = 0; ar_c = 0; end
                if (axi_awvalid) begin axi_awready = (aw_c >= aw_dly); aw_c++; end
                else begin axi_awready = 0; aw_c = 0; end
                if (axi_wvalid) begin axi_wready = (w_c >= w_dly); w_c++; end
                else begin axi_wready = 0; w_c = 0; end
                ar_f = axi_arvalid && axi_arready;
                aw_f = axi_awvalid && axi_awready;
                w_f  = axi_wvalid && axi_wready;
                r_f  = axi_rvalid && axi_rready;
                b_f  = axi_bvalid && axi_bready;
                if (ar_f) ar_a = axi_araddr;
                if (aw_f) aw_a = axi_awaddr;
                if (w_f) begin w_d = axi_wdata; w_s = axi_wstrb; end
            end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;     // accept-to-response cycles, -1 = not checked
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    exp_t        e;
    int          acc_cyc;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_wstrb;
    int          arv_cnt, awv_cnt, wv_cnt, awv_first, wv_first;
    bit          hold_prev = 0;
    logic [31:0] hold_data;
    logic        hold_err;
    int          last_resp_cyc = -10;
    bit          b2b_chk = 0;
    int          resp_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_q.delete();
                hold_prev = 0;
            end else begin
                if (req_valid && req_ready) begin
                    acc_q.push_back(cyc);
                    acc_addr = req_addr; acc_wdata = req_wdata; acc_wstrb = req_wstrb;
                    arv_cnt = 0; awv_cnt = 0; wv_cnt = 0; awv_first = -1; wv_first = -1;
                    if (b2b_chk) chk("b2b_accept_cycle", 32'(cyc), 32'(last_resp_cyc + 1));
                end
                if (axi_arvalid) begin
                    arv_cnt++;
                    chk("araddr", axi_araddr, acc_addr);
                end
                if (axi_awvalid) begin
                    awv_cnt++;
                    if (awv_first < 0) awv_first = cyc;
                    chk("awaddr", axi_awaddr, acc_addr);
                end
                if (axi_wvalid) begin
                    wv_cnt++;
                    if (wv_first < 0) wv_first = cyc;
                    chk("wdata", axi_wdata, acc_wdata);
                    chk("wstrb", 32'(axi_wstrb), 32'(acc_wstrb));
                end
                if (resp_valid) chk("req_ready_while_resp", 32'(req_ready), 32'h0);
                if (hold_prev) begin
                    chk("hold_resp_valid", 32'(resp_valid), 32'h1);
                    chk("hold_resp_rdata", resp_rdata, hold_data);
                    chk("hold_resp_err", 32'(resp_err), 32'(hold_err));
                end
                hold_prev = resp_valid && !resp_ready;
                hold_data = resp_rdata;
                hold_err  = resp_err;
                if (resp_valid && resp_ready) begin
                    resp_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_resp: rdata %0h with empty scoreboard", resp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                        if (acc_q.size() > 0) begin
                            acc_cyc = acc_q.pop_front();
                            if (e.lat >= 0) chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                        end
                    end
                    last_resp_cyc = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit push, input logic [31:0] erd, input bit eerr, input int lat);
        int n;
        if (push) exp_q.push_back('{rdata: erd, err: eerr, lat: lat});
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 200);
        if (!req_ready) timeout("req_accept");
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_cnt < target && n < 300) begin @(posedge clk); #1; n++; end
        if (resp_cnt < target) timeout("wait_resp");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'h0);
        chk({tag, "_arvalid"}, 32'(axi_arvalid), 32'h0);
        chk({tag, "_rready"}, 32'(axi_rready), 32'h0);
        chk({tag, "_awvalid"}, 32'(axi_awvalid), 32'h0);
        chk({tag, "_wvalid"}, 32'(axi_wvalid), 32'h0);
        chk({tag, "_bready"}, 32'(axi_bready), 32'h0);
        chk({tag, "_araddr"}, axi_araddr, 32'h0);
        chk({tag, "_awaddr"}, axi_awaddr, 32'h0);
        chk({tag, "_wdata"}, axi_wdata, 32'h0);
        chk({tag, "_wstrb"}, 32'(axi_wstrb), 32'h0);
        chk({tag, "_prot"}, 32'({axi_arprot, axi_awprot}), 32'h0);
    endtask

    int ar_hold, b_before, n;

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 1;
        mem[32'h0020_1004] = 32'h0000_000A;
        mem[32'h0000_0008] = 32'h1234_5678;
        mem[32'h0000_0100] = 32'hCAFE_0001;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'h1);
        @(posedge clk); #1;

        // Read, zero-wait slave.
        do_req(0, 32'h0020_1004, 32'h0, 4'h0, 1, 32'h0000_000A, 0, 3);
        wait_resp(1);
        chk("rd_arvalid_cycles", 32'(arv_cnt), 32'd1);

        // Write, zero-wait slave: AW and W together for one cycle.
        do_req(1, 32'h0000_0004, 32'h0000_0003, 4'hF, 1, 32'h0, 0, 3);
        wait_resp(2);
        chk("wr_awvalid_cycles", 32'(awv_cnt), 32'd1);
        chk("wr_wvalid_cycles", 32'(wv_cnt), 32'd1);
        chk("wr_aw_w_same_cycle", 32'(awv_first), 32'(wv_first));

        // AW accepted late, W immediately.
        aw_dly = 2; b_before = b_fires;
        do_req(1, 32'h0000_0010, 32'h55AA_1234, 4'h3, 1, 32'h0, 0, 5);
        wait_resp(3);
        aw_dly = 0;
        chk("skew_aw_awvalid_cycles", 32'(awv_cnt), 32'd3);
        chk("skew_aw_wvalid_cycles", 32'(wv_cnt), 32'd1);
        chk("skew_aw_b_count", 32'(b_fires - b_before), 32'd1);

        // W accepted late, AW immediately.
        w_dly = 1;
        do_req(1, 32'h0000_0014, 32'h0000_00C3, 4'hF, 1, 32'h0, 0, 4);
        wait_resp(4);
        w_dly = 0;
        chk("skew_w_awvalid_cycles", 32'(awv_cnt), 32'd1);
        chk("skew_w_wvalid_cycles", 32'(wv_cnt), 32'd2);

        // Error responses.
        r_resp = 2'b10;
        do_req(0, 32'h0000_0008, 32'h0, 4'h0, 1, 32'h1234_5678, 1, 3);
        wait_resp(5);
        r_resp = 2'b00; b_resp = 2'b11;
        do_req(1, 32'h0000_0018, 32'h0000_0077, 4'hF, 1, 32'h0, 1, 3);
        wait_resp(6);
        b_resp = 2'b00;

        // Response backpressure for 5 cycles, a request waiting meanwhile, then 3 back-to-back reads.
        resp_ready = 0;
        do_req(0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'hCAFE_0001, 0, 8);
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
        if (!resp_valid) timeout("stall_resp_valid");
        ar_hold = ar_fires;
        b2b_chk = 1;
        fork
            begin
                repeat (5) @(posedge clk);
                chk("stall_no_new_ar", 32'(ar_fires), 32'(ar_hold));
                #1 resp_ready = 1;
            end
            begin
                @(posedge clk); #1;
                do_req(0, 32'h0000_0004, 32'h0, 4'h0, 1, 32'h0000_0003, 0, 3);
                do_req(0, 32'h0000_0010, 32'h0, 4'h0, 1, 32'h0000_1234, 0, 3);
                do_req(0, 32'h0020_1004, 32'h0, 4'h0, 1, 32'h0000_000A, 0, 3);
            end
        join
        wait_resp(10);
        b2b_chk = 0;

        // Reset while waiting in RD_DATA after AR was accepted.
        r_dly = 20;
        do_req(0, 32'h0000_0020, 32'h0, 4'h0, 0, 32'h0, 0, -1);
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_rready && n < 50);
        if (!axi_rready) timeout("rd_data_state");
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 0; r_dly = 0;
        @(negedge clk);
        chk("req_ready_after_mid_reset", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        do_req(0, 32'h0020_1004, 32'h0, 4'h0, 1, 32'h0000_000A, 0, 3);
        wait_resp(11);

        chk("total_ar", 32'(ar_fires), 32'd8);
        chk("total_r", 32'(r_fires), 32'd7);
        chk("total_aw", 32'(aw_fires), 32'd4);
        chk("total_w", 32'(w_fires), 32'd4);
        chk("total_b", 32'(b_fires), 32'd4);
        chk("total_resp", 32'(resp_cnt), 32'd11);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
